// File: rtl/wb_rr_intercon.sv
// Multi-master Wishbone interconnect: round-robin grant, top-address slave decode, registered ACK/ERR.
// Optional busy watchdog enabled by defining WB_TIMEOUT_EN.
module wb_rr_intercon #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 16,
  parameter int SEL_BITS  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_stb,
  input  logic [N_MASTERS-1:0]    m_we,
  input  logic [32*N_MASTERS-1:0] m_addr,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack,
  output logic [N_MASTERS-1:0]    m_err,
  output logic [N_SLAVES-1:0]     s_stb,
  output logic                    s_we,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_dat_o,
  input  logic [32*N_SLAVES-1:0]  s_dat_i,
  input  logic [N_SLAVES-1:0]     s_ack
);
  // state | meaning
  // IDLE  | no cycle in flight, arbitrate on next edge
  // BUSY  | granted master's cycle strobed to decoded slave
  // RESP  | one-cycle ACK or ERR pulse to the granted master
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] g, g_nxt, lg, lg_nxt, winner;
  logic          found;
  logic          ack_f, ack_f_nxt, err_f, err_f_nxt;
  logic [31:0]   dat_q, dat_nxt;

  logic [31:0]         addr_g, wdat_g, rdat_sel;
  logic                we_g, stb_g, ack_sel, hit;
  logic [SEL_BITS-1:0] sel;

`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt, cnt_nxt;
  logic [16:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt} + 17'd1;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
`endif

  always_comb begin
    addr_g = '0;
    wdat_g = '0;
    we_g   = 1'b0;
    stb_g  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (g == GW'(i)) begin
        addr_g = m_addr[32*i +: 32];
        wdat_g = m_dat_i[32*i +: 32];
        we_g   = m_we[i];
        stb_g  = m_stb[i];
      end
    end
  end

  assign sel = addr_g[31 -: SEL_BITS];

  // A select value with no matching slave port is a decode miss.
  always_comb begin
    hit      = 1'b0;
    ack_sel  = 1'b0;
    rdat_sel = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (sel == SEL_BITS'(j)) begin
        hit      = 1'b1;
        ack_sel  = s_ack[j];
        rdat_sel = s_dat_i[32*j +: 32];
      end
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = lg;
    for (int k = 1; k <= N_MASTERS; k++) begin
      int idx;
      idx = (int'(lg) + k) % N_MASTERS;
      if (!found && m_stb[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      lg    <= GW'(N_MASTERS - 1);
      ack_f <= 1'b0;
      err_f <= 1'b0;
      dat_q <= '0;
`ifdef WB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      lg    <= lg_nxt;
      ack_f <= ack_f_nxt;
      err_f <= err_f_nxt;
      dat_q <= dat_nxt;
`ifdef WB_TIMEOUT_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    lg_nxt    = lg;
    ack_f_nxt = ack_f;
    err_f_nxt = err_f;
    dat_nxt   = dat_q;
`ifdef WB_TIMEOUT_EN
    cnt_nxt   = '0;
`endif
    case (state)
      IDLE: begin
        ack_f_nxt = 1'b0;
        err_f_nxt = 1'b0;
        if (found) begin
          g_nxt     = winner;
          lg_nxt    = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!stb_g) begin
          state_nxt = IDLE;
        end else if (!hit) begin
          err_f_nxt = 1'b1;
          dat_nxt   = '0;
          state_nxt = RESP;
        end else if (ack_sel) begin
          ack_f_nxt = 1'b1;
          dat_nxt   = rdat_sel;
          state_nxt = RESP;
`ifdef WB_TIMEOUT_EN
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          err_f_nxt = 1'b1;
          dat_nxt   = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_inc[15:0];
`endif
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_stb   = '0;
    m_ack   = '0;
    m_err   = '0;
    s_we    = we_g;
    s_dat_o = wdat_g;
    s_addr  = addr_g;
    s_addr[31 -: SEL_BITS] = '0;
    for (int j = 0; j < N_SLAVES; j++)
      s_stb[j] = (state == BUSY) && stb_g && (sel == SEL_BITS'(j));
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ack[i] = (state == RESP) && ack_f && (g == GW'(i));
      m_err[i] = (state == RESP) && err_f && (g == GW'(i));
    end
  end

  assign m_dat_o = dat_q;

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Directed bench for wb_rr_intercon: 2 masters, 12 slaves (so 0xC..0xF decode-miss).
// Timeout steps run only when WB_TIMEOUT_EN is defined (TIMEOUT=8).
module tb_wb_rr_intercon;
  localparam int NM = 2;
  localparam int NS = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  m_stb, m_we, m_ack, m_err;
  logic [32*NM-1:0] m_addr, m_dat_i;
  logic [31:0]    m_dat_o, s_addr, s_dat_o;
  logic [NS-1:0]  s_stb, s_ack, ack_en, ack_force;
  logic           s_we;
  logic [32*NS-1:0] s_dat_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign s_ack = (s_stb & ack_en) | ack_force;

  wb_rr_intercon #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_BITS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NM-1:0] rr_winner;
    rst = 1'b1; m_stb = '0; m_we = '0; m_addr = '0; m_dat_i = '0;
    ack_en = '0; ack_force = '0;
    for (int j = 0; j < NS; j++)
      s_dat_i[32*j +: 32] = (j == 5) ? 32'h1234_5678 : (32'hA000_0000 | 32'(j));
    tick(); tick();
    rst = 1'b0;
    check("rst_m_ack", 32'(m_ack), 32'h0);
    check("rst_m_err", 32'(m_err), 32'h0);
    check("rst_m_dat_o", m_dat_o, 32'h0);
    check("rst_s_stb", 32'(s_stb), 32'h0);

    // single write, combinational ACK from slave 3
    m_stb = 2'b01; m_we = 2'b01; m_addr[31:0] = 32'h3000_0010; m_dat_i[31:0] = 32'hDEAD_BEEF;
    ack_en = 12'h008;
    tick();
    check("wr_s_stb", 32'(s_stb), 32'h008);
    check("wr_s_addr", s_addr, 32'h0000_0010);
    check("wr_s_dat_o", s_dat_o, 32'hDEAD_BEEF);
    check("wr_s_we", 32'(s_we), 32'h1);
    check("wr_ack_c1", 32'(m_ack), 32'h0);
    tick();
    check("wr_ack_c2", 32'(m_ack), 32'h1);
    check("wr_dat", m_dat_o, 32'hA000_0003);
    check("wr_s_stb_resp", 32'(s_stb), 32'h0);
    m_stb = '0;
    tick();
    check("wr_ack_c3", 32'(m_ack), 32'h0);

    // read from slave 5 with 4-cycle wait; stray ACK on slave 7 must be ignored
    m_stb = 2'b10; m_we = '0; m_addr[63:32] = 32'h5000_0000; ack_en = '0; ack_force = 12'h080;
    tick();
    for (int c = 1; c <= 4; c++) begin
      check("rd_wait_stb", 32'(s_stb), 32'h020);
      check("rd_wait_ack", 32'(m_ack), 32'h0);
      if (c == 4) begin
        ack_force = '0;
        ack_en = 12'h020;
      end
      tick();
    end
    check("rd_ack", 32'(m_ack), 32'h2);
    check("rd_dat", m_dat_o, 32'h1234_5678);
    m_stb = '0; ack_en = '0;
    tick();
    check("rd_idle_ack", 32'(m_ack), 32'h0);

    // round-robin: master 0 -> slave 1, master 1 -> slave 2
    m_addr[31:0] = 32'h1000_0000; m_addr[63:32] = 32'h2000_0000;
    ack_en = '1; m_stb = 2'b11;
    for (int n = 0; n < 4; n++) begin
      rr_winner = (n % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("rr_s_stb", 32'(s_stb), (n % 2 == 0) ? 32'h002 : 32'h004);
      tick();
      check("rr_ack", 32'(m_ack), 32'(rr_winner));
      m_stb = m_stb & ~rr_winner;
      tick();
      m_stb = (n < 3) ? 2'b11 : 2'b00;
    end
    check("rr_last_dat", m_dat_o, 32'hA000_0002);

    // decode miss: 0xE is beyond 12 slaves
    m_addr[31:0] = 32'hE000_0000; m_stb = 2'b01;
    tick();
    check("miss_s_stb", 32'(s_stb), 32'h0);
    check("miss_err_c1", 32'(m_err), 32'h0);
    tick();
    check("miss_err_c2", 32'(m_err), 32'h1);
    check("miss_ack_c2", 32'(m_ack), 32'h0);
    check("miss_dat", m_dat_o, 32'h0);
    m_stb = '0;
    tick();
    check("miss_err_c3", 32'(m_err), 32'h0);

    // abort: master 1 drops strobe before ACK
    m_addr[63:32] = 32'h6000_0000; m_stb = 2'b10; ack_en = '0;
    tick();
    check("abort_s_stb", 32'(s_stb), 32'h040);
    m_stb = '0;
    tick();
    check("abort_s_stb_off", 32'(s_stb), 32'h0);
    check("abort_ack", 32'({m_ack, m_err}), 32'h0);
    tick();
    check("abort_ack2", 32'({m_ack, m_err}), 32'h0);

    // reset while master 0 holds slave 4; afterwards master 0 must win the tie again
    m_addr[31:0] = 32'h4000_0000; m_stb = 2'b01;
    tick();
    check("rst_busy_stb", 32'(s_stb), 32'h010);
    rst = 1'b1;
    tick();
    check("rst_busy_stb_off", 32'(s_stb), 32'h0);
    check("rst_busy_resp", 32'({m_ack, m_err}), 32'h0);
    rst = 1'b0; m_stb = 2'b11; ack_en = '1;
    tick();
    check("rst_first_grant", 32'(s_stb), 32'h010);
    tick();
    check("rst_first_ack", 32'(m_ack), 32'h1);
    check("rst_first_dat", m_dat_o, 32'hA000_0004);
    m_stb = '0; ack_en = '0;
    tick();

`ifdef WB_TIMEOUT_EN
    // watchdog: slave 2 never answers
    m_addr[31:0] = 32'h2000_0000; m_stb = 2'b01;
    tick();
    for (int c = 0; c < 8; c++) begin
      check("to_busy_stb", 32'(s_stb), 32'h004);
      check("to_busy_err", 32'(m_err), 32'h0);
      tick();
    end
    check("to_err", 32'(m_err), 32'h1);
    check("to_s_stb", 32'(s_stb), 32'h0);
    check("to_dat", m_dat_o, 32'h0);
    m_stb = '0;
    tick();
    check("to_err_off", 32'(m_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
